// File: rtl/mem_pair_writer.sv
`default_nettype none
// ============================================================================
// Module  : mem_pair_writer
// Purpose : Stores a latched (addr_A,data_A),(addr_B,data_B) pair to memory
//           as two strobed writes, each followed by WAIT_CYCLES hold cycles.
// Revision: 1.0 - initial release
// ============================================================================
module mem_pair_writer #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] addr_A,
  input  logic [31:0] addr_B,
  input  logic [31:0] data_A,
  input  logic [31:0] data_B,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wr,
  output logic        busy,
  output logic        done
);

  // Counter is loaded with WAIT_CYCLES-1 so HOLD lasts exactly WAIT_CYCLES cycles.
  localparam bit       c_SKIP_HOLD = (WAIT_CYCLES == 0);
  localparam logic [3:0] c_HOLD_LOAD = c_SKIP_HOLD ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WR_A   = 3'd1,
    S_HOLD_A = 3'd2,
    S_WR_B   = 3'd3,
    S_HOLD_B = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_a_q, addr_a_d;
  logic [31:0] addr_b_q, addr_b_d;
  logic [31:0] data_a_q, data_a_d;
  logic [31:0] data_b_q, data_b_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      addr_a_q <= 32'd0;
      addr_b_q <= 32'd0;
      data_a_q <= 32'd0;
      data_b_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_a_d = addr_a_q;
    addr_b_d = addr_b_q;
    data_a_d = data_a_q;
    data_b_d = data_b_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_a_d = addr_A;
          addr_b_d = addr_B;
          data_a_d = data_A;
          data_b_d = data_B;
          state_d  = S_WR_A;
        end
      end
      S_WR_A: begin
        cnt_d   = c_HOLD_LOAD;
        state_d = c_SKIP_HOLD ? S_WR_B : S_HOLD_A;
      end
      S_HOLD_A: begin
        if (cnt_q == 4'd0) state_d = S_WR_B;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_WR_B: begin
        cnt_d   = c_HOLD_LOAD;
        state_d = c_SKIP_HOLD ? S_DONE : S_HOLD_B;
      end
      S_HOLD_B: begin
        if (cnt_q == 4'd0) state_d = S_DONE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs: decoded purely from registered state and latched pair.
  always_comb begin
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    mem_wr    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      S_WR_A, S_HOLD_A: begin
        mem_addr  = addr_a_q;
        mem_wdata = data_a_q;
        mem_wr    = (state_q == S_WR_A);
        busy      = 1'b1;
      end
      S_WR_B, S_HOLD_B: begin
        mem_addr  = addr_b_q;
        mem_wdata = data_b_q;
        mem_wr    = (state_q == S_WR_B);
        busy      = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_pair_writer.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_pair_writer
// Purpose : Checks three mem_pair_writer instances (WAIT 1/0/3) against a
//           timeline reference model under directed and random stimulus.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_pair_writer;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] addr_A, addr_B, data_A, data_B;
  logic [31:0] ma [3];
  logic [31:0] wd [3];
  logic        wr [3];
  logic        bz [3];
  logic        dn [3];

  always #5 clk = ~clk;

  mem_pair_writer #(.WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .reset(reset), .start(start),
    .addr_A(addr_A), .addr_B(addr_B), .data_A(data_A), .data_B(data_B),
    .mem_addr(ma[0]), .mem_wdata(wd[0]), .mem_wr(wr[0]), .busy(bz[0]), .done(dn[0]));
  mem_pair_writer #(.WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .reset(reset), .start(start),
    .addr_A(addr_A), .addr_B(addr_B), .data_A(data_A), .data_B(data_B),
    .mem_addr(ma[1]), .mem_wdata(wd[1]), .mem_wr(wr[1]), .busy(bz[1]), .done(dn[1]));
  mem_pair_writer #(.WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .reset(reset), .start(start),
    .addr_A(addr_A), .addr_B(addr_B), .data_A(data_A), .data_B(data_B),
    .mem_addr(ma[2]), .mem_wdata(wd[2]), .mem_wr(wr[2]), .busy(bz[2]), .done(dn[2]));

  int          total = 0;
  int          bad   = 0;
  int          wv [3] = '{1, 0, 3};
  // Edges elapsed since the accepted start; -1 when no request is active.
  int          since [3] = '{-1, -1, -1};
  logic [31:0] la [3], lb [3], lda [3], ldb [3];
  bit   [31:0] mem [bit [31:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic [31:0] aa, input logic [31:0] ab,
                      input logic [31:0] da, input logic [31:0] db);
    reset = r; start = s; addr_A = aa; addr_B = ab; data_A = da; data_B = db;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (r) since[i] = -1;
      else if (since[i] < 0 || since[i] >= 2 * wv[i] + 3) begin
        if (s) begin
          since[i] = 0;
          la[i] = aa; lb[i] = ab; lda[i] = da; ldb[i] = db;
        end else since[i] = -1;
      end else since[i]++;
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      int          j   = since[i];
      int          w   = wv[i];
      bit          act = (j >= 0) && (j <= 2 * w + 2);
      logic [31:0] ea  = 32'd0;
      logic [31:0] ed  = 32'd0;
      if (act && j <= w) begin ea = la[i]; ed = lda[i]; end
      else if (act && j <= 2 * w + 1) begin ea = lb[i]; ed = ldb[i]; end
      chk($sformatf("w%0d.mem_addr", w),  ma[i], ea);
      chk($sformatf("w%0d.mem_wdata", w), wd[i], ed);
      chk($sformatf("w%0d.mem_wr", w),    32'(wr[i]), 32'(act && (j == 0 || j == w + 1)));
      chk($sformatf("w%0d.busy", w),      32'(bz[i]), 32'(act && j <= 2 * w + 1));
      chk($sformatf("w%0d.done", w),      32'(dn[i]), 32'(act && j == 2 * w + 2));
    end
    if (wr[0] === 1'b1) mem[ma[0]] = wd[0];
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
  endtask

  initial begin
    // Reset state
    step(1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    step(1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    idle(2);

    // Basic pair
    step(1'b0, 1'b1, 32'h10, 32'h14, 32'hAAAA0001, 32'h55550002);
    idle(10);

    // Inputs corrupted and start held high during the sequence
    step(1'b0, 1'b1, 32'h40, 32'h44, 32'h12345678, 32'h9ABCDEF0);
    for (int k = 0; k < 14; k++)
      step(1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    idle(12);

    // Reset during HOLD_A (for the WAIT=1 and WAIT=3 instances)
    step(1'b0, 1'b1, 32'h80, 32'h84, 32'h11111111, 32'h22222222);
    idle(1);
    step(1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    idle(10);

    // Same address for both words: B must land last
    step(1'b0, 1'b1, 32'h20, 32'h20, 32'd1, 32'd2);
    idle(10);
    chk("mem_same_addr", mem.exists(32'h20) ? mem[32'h20] : 32'hDEADBEEF, 32'd2);
    chk("mem_no_write_after_abort", 32'(mem.exists(32'h84)), 32'd0);

    // Reset and start on the same edge
    step(1'b1, 1'b1, 32'h30, 32'h34, 32'd7, 32'd8);
    idle(4);

    // Random traffic
    for (int k = 0; k < 400; k++)
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 2) == 0),
           $urandom(), $urandom(), $urandom(), $urandom());
    idle(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
